// File: rtl/registers_bank_dumper.sv
// Register bank dumper: snapshots the flattened GPR bank when start is seen and
// streams it out byte-by-byte over valid/ready, register 0 first, MSB first.
module registers_bank_dumper #(
  parameter int REGISTERS_BANK_SIZE = 32,
  parameter int REGISTERS_SIZE      = 32,
  parameter int BYTE_SIZE           = 8
) (
  input  logic                                        i_clk,
  input  logic                                        i_reset,
  input  logic                                        i_start,
  input  logic [REGISTERS_BANK_SIZE*REGISTERS_SIZE-1:0] i_bus_debug,
  input  logic                                        i_ready,
  output logic [BYTE_SIZE-1:0]                        o_data,
  output logic                                        o_valid,
  output logic                                        o_busy,
  output logic                                        o_done
);

  // state | meaning
  // IDLE  | waiting for i_start, outputs quiet
  // SEND  | presenting snapshot byte cnt_q, advancing on each transfer
  // DONE  | single-cycle o_done pulse, then back to IDLE

  localparam int TOTAL_BITS = REGISTERS_BANK_SIZE * REGISTERS_SIZE;
  localparam int N_BYTES    = TOTAL_BITS / BYTE_SIZE;
  localparam int BPR        = REGISTERS_SIZE / BYTE_SIZE;
  localparam int CW         = $clog2(N_BYTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [TOTAL_BITS-1:0]   snap_q;
  logic [CW-1:0]           cnt_q;
  logic [CW-1:0]           cnt_d;
  logic [BYTE_SIZE-1:0]    data_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    done_q;

  // Byte k of the dump lives in register k/BPR, byte lane BPR-1-(k%BPR).
  function automatic logic [BYTE_SIZE-1:0] pick_byte(
    input logic [TOTAL_BITS-1:0] bank,
    input logic [CW-1:0]         idx
  );
    int reg_i;
    int lane;
    reg_i = int'(idx) / BPR;
    lane  = BPR - 1 - (int'(idx) % BPR);
    return bank[reg_i*REGISTERS_SIZE + lane*BYTE_SIZE +: BYTE_SIZE];
  endfunction

  assign cnt_d = cnt_q + CW'(1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (i_start) begin
            snap_q  <= i_bus_debug;
            cnt_q   <= '0;
            // First byte comes straight from the bus so it is valid next cycle.
            data_q  <= pick_byte(i_bus_debug, '0);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (i_ready) begin
            if (cnt_q == LAST_IDX) begin
              data_q  <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q  <= cnt_d;
              data_q <= pick_byte(snap_q, cnt_d);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule
